// File: rtl/i2s_receiver_pkg.sv
// Shared definitions for the I2S receive path: FSM encoding, WS polarity,
// default word/slot sizes (common with the transmit side) and slot status flags.
package i2s_receiver_pkg;

  localparam int unsigned I2S_NUM_BITS  = 24;
  localparam int unsigned I2S_SLOT_BITS = 32;

  localparam logic WS_LEFT = 1'b0;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_e;

  // Per-strobe slot status reported by the slot tracker.
  typedef struct packed {
    logic done;   // final data bit is on serial_in this strobe
    logic early;  // WS changed before a full word was shifted
    logic over;   // slot ran to SLOT_BITS without a WS change
  } slot_flags_t;

endpackage

// File: rtl/i2s_rx_slot.sv
// Per-slot bit counter and MSB-first shift register for the I2S receiver.
// Strobe 0 is the WS-change strobe; data bits occupy strobes 1..NUM_BITS.
module i2s_rx_slot
  import i2s_receiver_pkg::*;
#(
  parameter int unsigned NUM_BITS  = I2S_NUM_BITS,
  parameter int unsigned SLOT_BITS = I2S_SLOT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                strobe,
  input  logic                ws_change,
  input  logic                active,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] word_c,
  output slot_flags_t         flags_c
);

  localparam int unsigned CW = $clog2(SLOT_BITS + 1);

  logic [CW-1:0]       cnt;
  logic [CW-1:0]       idx;
  logic [NUM_BITS-2:0] shift;
  logic                bit_en;

  // idx is the position of the current strobe within the slot.
  assign idx    = cnt + CW'(1);
  assign word_c = {shift, serial_in};
  assign bit_en = strobe && active && !ws_change && (idx <= CW'(NUM_BITS));

  always_comb begin
    flags_c = '0;
    if (strobe && active) begin
      if (ws_change) begin
        flags_c.early = (cnt < CW'(NUM_BITS));
      end else begin
        flags_c.done = (idx == CW'(NUM_BITS));
        flags_c.over = (idx == CW'(SLOT_BITS));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      shift <= '0;
    end else if (strobe) begin
      if (!active || ws_change || flags_c.over) begin
        cnt <= '0;
      end else begin
        cnt <= idx;
      end
      if (ws_change) begin
        shift <= '0;
      end else if (bit_en) begin
        shift <= word_c[NUM_BITS-2:0];
      end
    end
  end

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S stereo deserialiser on the system clock, sampling on an SCK strobe.
// Optional I2S_RX_ERR_CNT_EN adds a saturating framing-error counter output.
module i2s_receiver
  import i2s_receiver_pkg::*;
#(
  parameter int unsigned NUM_BITS  = I2S_NUM_BITS,
  parameter int unsigned SLOT_BITS = I2S_SLOT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_clk_pos,
  input  logic                word_select,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] left_word,
  output logic [NUM_BITS-1:0] right_word,
  output logic                word_valid,
  output logic                frame_err
`ifdef I2S_RX_ERR_CNT_EN
  ,
  output logic [7:0]          err_count
`endif
);

  state_e              state;
  state_e              state_d;
  logic                ws_q;
  logic                ws_change;
  logic                left_ok;
  logic                left_ok_d;
  logic                load_left_c;
  logic                load_right_c;
  logic                valid_d;
  logic                err_d;
  logic [NUM_BITS-1:0] word_c;
  slot_flags_t         flags_c;

  assign ws_change = s_clk_pos && (word_select != ws_q);

  i2s_rx_slot #(
    .NUM_BITS (NUM_BITS),
    .SLOT_BITS(SLOT_BITS)
  ) u_slot (
    .clk      (clk),
    .rst      (rst),
    .strobe   (s_clk_pos),
    .ws_change(ws_change),
    .active   (state != SYNC),
    .serial_in(serial_in),
    .word_c   (word_c),
    .flags_c  (flags_c)
  );

  // left_ok remembers a captured left word so word_valid only marks a full pair.
  always_comb begin
    state_d      = state;
    left_ok_d    = left_ok;
    load_left_c  = 1'b0;
    load_right_c = 1'b0;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    case (state)
      SYNC: begin
        if (ws_change && (word_select == WS_LEFT)) begin
          state_d   = LEFT;
          left_ok_d = 1'b0;
        end
      end
      LEFT: begin
        if (flags_c.over) begin
          err_d     = 1'b1;
          state_d   = SYNC;
          left_ok_d = 1'b0;
        end else if (ws_change) begin
          state_d = RIGHT;
          if (flags_c.early) begin
            err_d     = 1'b1;
            left_ok_d = 1'b0;
          end
        end else if (flags_c.done) begin
          load_left_c = 1'b1;
          left_ok_d   = 1'b1;
        end
      end
      RIGHT: begin
        if (flags_c.over) begin
          err_d     = 1'b1;
          state_d   = SYNC;
          left_ok_d = 1'b0;
        end else if (ws_change) begin
          state_d   = LEFT;
          left_ok_d = 1'b0;
          err_d     = flags_c.early;
        end else if (flags_c.done) begin
          load_right_c = 1'b1;
          valid_d      = left_ok;
          left_ok_d    = 1'b0;
        end
      end
      default: begin
        state_d   = SYNC;
        left_ok_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      ws_q       <= WS_LEFT;
      left_ok    <= 1'b0;
      left_word  <= '0;
      right_word <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      left_ok    <= left_ok_d;
      word_valid <= valid_d;
      frame_err  <= err_d;
      if (s_clk_pos) begin
        ws_q <= word_select;
      end
      if (load_left_c) begin
        left_word <= word_c;
      end
      if (load_right_c) begin
        right_word <= word_c;
      end
    end
  end

`ifdef I2S_RX_ERR_CNT_EN
  // Counts alongside frame_err and sticks at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (err_d && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: random slot streams against a slot-level model.
// Also exercises the I2S_RX_ERR_CNT_EN counter when that macro is defined.
module tb_i2s_receiver;
  import i2s_receiver_pkg::*;

  localparam int unsigned NB  = 24;
  localparam int unsigned SB  = 32;
  localparam int unsigned GAP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_clk_pos;
  logic          word_select;
  logic          serial_in;
  logic [NB-1:0] left_word;
  logic [NB-1:0] right_word;
  logic          word_valid;
  logic          frame_err;
`ifdef I2S_RX_ERR_CNT_EN
  logic [7:0]    err_count;
`endif

  int checks = 0;
  int errors = 0;

  // Slot-level reference state
  bit            m_locked;
  bit            m_pair;
  logic          m_ws;
  int            m_bits;
  int            m_errs;
  logic [NB-1:0] m_left;
  logic [NB-1:0] m_right;

  logic [127:0]  ov, xv, oe, xe;
  logic [NB-1:0] gw, xw;

  i2s_receiver #(
    .NUM_BITS (NB),
    .SLOT_BITS(SB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_clk_pos  (s_clk_pos),
    .word_select(word_select),
    .serial_in  (serial_in),
    .left_word  (left_word),
    .right_word (right_word),
    .word_valid (word_valid),
    .frame_err  (frame_err)
`ifdef I2S_RX_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_locked = 0;
    m_pair   = 0;
    m_ws     = WS_LEFT;
    m_bits   = 0;
    m_errs   = 0;
    m_left   = '0;
    m_right  = '0;
  endtask

  // Sends one slot: a WS-change strobe followed by len-1 data strobes.
  // Returns per-cycle observed/expected pulse maps and the channel word after capture.
  task automatic send_slot(input logic ws, input int len, input logic [NB-1:0] data,
                           output logic [127:0] o_v, output logic [127:0] x_v,
                           output logic [127:0] o_e, output logic [127:0] x_e,
                           output logic [NB-1:0] g_w, output logic [NB-1:0] x_w);
    bit lock;
    bit captured;
    int cyc;
    o_v = '0; x_v = '0; o_e = '0; x_e = '0;
    cyc = 0;
    captured = 0;
    g_w = '0;
    lock = m_locked || (ws == WS_LEFT);
    if (ws == WS_LEFT) m_pair = 0;
    for (int k = 0; k < len; k++) begin
      logic sd, ev, ee;
      sd = 1'($urandom);
      ev = 1'b0;
      ee = 1'b0;
      if (k == 0) begin
        ee = m_locked && (ws != m_ws) && (m_bits < int'(NB));
      end else if (lock) begin
        if (k <= int'(NB)) sd = data[NB-k];
        if (k == int'(NB)) begin
          captured = 1;
          if (ws == WS_LEFT) begin
            m_left = data;
            m_pair = 1;
          end else begin
            m_right = data;
            ev = m_pair;
            m_pair = 0;
          end
        end
        if (k == int'(SB)) begin
          ee = 1'b1;
          lock = 0;
        end
      end
      if (ee && m_errs < 255) m_errs++;
      word_select = ws;
      serial_in   = sd;
      s_clk_pos   = 1'b1;
      x_v[cyc] = ev;
      x_e[cyc] = ee;
      @(posedge clk); #1;
      s_clk_pos = 1'b0;
      o_v[cyc] = word_valid;
      o_e[cyc] = frame_err;
      cyc++;
      if (k == int'(NB) && captured) g_w = (ws == WS_LEFT) ? left_word : right_word;
      repeat (GAP) begin
        @(posedge clk); #1;
        o_v[cyc] = word_valid;
        o_e[cyc] = frame_err;
        cyc++;
      end
    end
    if (captured) begin
      x_w = data;
    end else begin
      g_w = (ws == WS_LEFT) ? left_word : right_word;
      x_w = (ws == WS_LEFT) ? m_left : m_right;
    end
    m_locked = lock;
    m_ws     = ws;
    m_bits   = len - 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_clk_pos = 1'b0;
    word_select = 1'b0;
    serial_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (left_word !== '0) begin errors++; $display("FAIL reset_left got=%h exp=0", left_word); end
    checks++; if (right_word !== '0) begin errors++; $display("FAIL reset_right got=%h exp=0", right_word); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    checks++; if (dut.state !== SYNC) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, SYNC); end
`ifdef I2S_RX_ERR_CNT_EN
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
`endif
  endtask

  task automatic test_mid_start();
    logic ws_l[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int   len_l[5] = '{9, 32, 32, 32, 32};
    for (int i = 0; i < 5; i++) begin
      send_slot(ws_l[i], len_l[i], NB'($urandom), ov, xv, oe, xe, gw, xw);
      checks++; if (ov !== xv) begin errors++; $display("FAIL mid_start[%0d] valid got=%h exp=%h", i, ov, xv); end
      checks++; if (oe !== xe) begin errors++; $display("FAIL mid_start[%0d] err got=%h exp=%h", i, oe, xe); end
      checks++; if (gw !== xw) begin errors++; $display("FAIL mid_start[%0d] word got=%h exp=%h", i, gw, xw); end
    end
  endtask

  task automatic test_loopback();
    for (int i = 0; i < 8; i++) begin
      logic ws;
      ws = (i % 2 == 0) ? WS_LEFT : ~WS_LEFT;
      send_slot(ws, 32, (ws == WS_LEFT) ? 24'h123456 : 24'hABCDEF, ov, xv, oe, xe, gw, xw);
      checks++; if (ov !== xv) begin errors++; $display("FAIL loopback[%0d] valid got=%h exp=%h", i, ov, xv); end
      checks++; if (oe !== '0) begin errors++; $display("FAIL loopback[%0d] err got=%h exp=0", i, oe); end
      checks++; if (gw !== xw) begin errors++; $display("FAIL loopback[%0d] word got=%h exp=%h", i, gw, xw); end
    end
    checks++; if (left_word !== 24'h123456) begin errors++; $display("FAIL loopback_left got=%h exp=123456", left_word); end
    checks++; if (right_word !== 24'hABCDEF) begin errors++; $display("FAIL loopback_right got=%h exp=abcdef", right_word); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int len;
      len = (i == 0) ? int'(NB) + 1 : (i == 1) ? int'(SB) : int'($urandom_range(SB, NB + 1));
      send_slot((i % 2 == 0) ? WS_LEFT : ~WS_LEFT, len, NB'($urandom), ov, xv, oe, xe, gw, xw);
      checks++; if (ov !== xv) begin errors++; $display("FAIL random[%0d] valid got=%h exp=%h", i, ov, xv); end
      checks++; if (oe !== xe) begin errors++; $display("FAIL random[%0d] err got=%h exp=%h", i, oe, xe); end
      checks++; if (gw !== xw) begin errors++; $display("FAIL random[%0d] word got=%h exp=%h", i, gw, xw); end
    end
  endtask

  task automatic test_short_slot();
    int len_l[8] = '{11, 32, 32, 32, 32, 24, 32, 32};
    for (int i = 0; i < 8; i++) begin
      send_slot((i % 2 == 0) ? WS_LEFT : ~WS_LEFT, len_l[i], NB'($urandom), ov, xv, oe, xe, gw, xw);
      checks++; if (ov !== xv) begin errors++; $display("FAIL short[%0d] valid got=%h exp=%h", i, ov, xv); end
      checks++; if (oe !== xe) begin errors++; $display("FAIL short[%0d] err got=%h exp=%h", i, oe, xe); end
      checks++; if (gw !== xw) begin errors++; $display("FAIL short[%0d] word got=%h exp=%h", i, gw, xw); end
      checks++; if ({left_word, right_word} !== {m_left, m_right}) begin
        errors++; $display("FAIL short[%0d] words got=%h/%h exp=%h/%h", i, left_word, right_word, m_left, m_right);
      end
    end
  endtask

  task automatic test_hold();
    int len_l[8] = '{41, 32, 32, 34, 32, 32, 32, 32};
    for (int i = 0; i < 8; i++) begin
      send_slot((i % 2 == 0) ? WS_LEFT : ~WS_LEFT, len_l[i], NB'($urandom), ov, xv, oe, xe, gw, xw);
      checks++; if (ov !== xv) begin errors++; $display("FAIL hold[%0d] valid got=%h exp=%h", i, ov, xv); end
      checks++; if (oe !== xe) begin errors++; $display("FAIL hold[%0d] err got=%h exp=%h", i, oe, xe); end
      checks++; if (gw !== xw) begin errors++; $display("FAIL hold[%0d] word got=%h exp=%h", i, gw, xw); end
      if (i == 0) begin
        checks++; if (dut.state !== SYNC) begin errors++; $display("FAIL hold_sync got=%0d exp=%0d", dut.state, SYNC); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int len_l[4] = '{32, 32, 32, 6};
    for (int i = 0; i < 4; i++) begin
      send_slot((i % 2 == 0) ? WS_LEFT : ~WS_LEFT, len_l[i], NB'($urandom), ov, xv, oe, xe, gw, xw);
    end
    word_select = ~WS_LEFT;
    serial_in   = 1'b1;
    s_clk_pos   = 1'b1;
    rst         = 1'b1;
    @(posedge clk); #1;
    s_clk_pos = 1'b0;
    rst       = 1'b0;
    model_reset();
    checks++; if (left_word !== '0) begin errors++; $display("FAIL rst_mid_left got=%h exp=0", left_word); end
    checks++; if (right_word !== '0) begin errors++; $display("FAIL rst_mid_right got=%h exp=0", right_word); end
    checks++; if ({word_valid, frame_err} !== 2'b00) begin errors++; $display("FAIL rst_mid_pulses got=%b exp=00", {word_valid, frame_err}); end
    checks++; if (dut.state !== SYNC) begin errors++; $display("FAIL rst_mid_state got=%0d exp=%0d", dut.state, SYNC); end
`ifdef I2S_RX_ERR_CNT_EN
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_mid_errcnt got=%0d exp=0", err_count); end
`endif
    for (int i = 0; i < 3; i++) begin
      send_slot((i % 2 == 0) ? ~WS_LEFT : WS_LEFT, (i == 0) ? 20 : 32, NB'($urandom), ov, xv, oe, xe, gw, xw);
      checks++; if (ov !== xv) begin errors++; $display("FAIL rst_resync[%0d] valid got=%h exp=%h", i, ov, xv); end
      checks++; if (oe !== xe) begin errors++; $display("FAIL rst_resync[%0d] err got=%h exp=%h", i, oe, xe); end
      checks++; if (gw !== xw) begin errors++; $display("FAIL rst_resync[%0d] word got=%h exp=%h", i, gw, xw); end
    end
  endtask

  task automatic test_err_saturate();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    send_slot(~WS_LEFT, 1, NB'($urandom), ov, xv, oe, xe, gw, xw);
    send_slot(WS_LEFT, 2, NB'($urandom), ov, xv, oe, xe, gw, xw);
    for (int i = 0; i < 300; i++) begin
      send_slot((i % 2 == 0) ? ~WS_LEFT : WS_LEFT, 2, NB'($urandom), ov, xv, oe, xe, gw, xw);
      checks++; if (oe !== xe) begin errors++; $display("FAIL sat[%0d] err got=%h exp=%h", i, oe, xe); end
      checks++; if (ov !== '0) begin errors++; $display("FAIL sat[%0d] valid got=%h exp=0", i, ov); end
`ifdef I2S_RX_ERR_CNT_EN
      checks++; if (err_count !== 8'(m_errs)) begin errors++; $display("FAIL sat[%0d] errcnt got=%0d exp=%0d", i, err_count, m_errs); end
`endif
    end
`ifdef I2S_RX_ERR_CNT_EN
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_final errcnt got=%0d exp=255", err_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_mid_start();
    test_loopback();
    test_random();
    test_short_slot();
    test_hold();
    test_reset_mid();
    test_err_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Deserialises a standard Philips I2S stereo stream into parallel left/right words.
- Receive-side counterpart of the synth's I2S transmit path. Used for line-in capture and for closed-loop checking of the DAC serial output.
- Runs on the system clock. Bit timing comes from a one-cycle rising-SCK strobe generated elsewhere, so no second clock domain.

Parameters:
- NUM_BITS, 24, captured audio word width (MSB first).
- SLOT_BITS, 32, maximum SCK periods per channel slot before a framing error; must be >= NUM_BITS+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_clk_pos  in  1  one-clk strobe marking each rising SCK edge; all serial sampling happens only on this strobe.
- word_select  in  1  I2S WS; 0 = left, 1 = right.
- serial_in  in  1  I2S SD.
- left_word  out  NUM_BITS  last complete left sample.
- right_word  out  NUM_BITS  last complete right sample.
- word_valid  out  1  one-clk pulse when a left+right pair has been updated.
- frame_err  out  1  one-clk pulse on a framing violation.

Behaviour:
- Reset values: left_word=0, right_word=0, word_valid=0, frame_err=0, state=SYNC, bit counter=0, shift register=0.
- rst has priority over a coincident s_clk_pos. A reset mid-frame discards the partial word and returns to SYNC.
- On each s_clk_pos: ws_q <= word_select. A WS change is detected when word_select != ws_q.
- At the strobe where the WS change is detected:
  - serial_in is the LSB slot of the previous channel and is ignored.
  - The bit counter is cleared to 0.
- Strobes with counter 1..NUM_BITS shift serial_in into the shift register, MSB first. The counter increments on every strobe while in LEFT or RIGHT.
- Bits after NUM_BITS and before the next WS change are ignored.
- States:
  - SYNC: wait for a WS 1->0 transition, then go to LEFT. Any other activity is ignored, with no error.
  - LEFT: on the strobe capturing bit NUM_BITS, load left_word from the shift register combined with that bit. Go to RIGHT on a WS 0->1 change.
  - RIGHT: on the strobe capturing bit NUM_BITS, load right_word the same way, then pulse word_valid on the next clk. Go to LEFT on a WS 1->0 change.
- Latency: left_word/right_word update, and word_valid asserts, 1 clk after the s_clk_pos that samples the final bit.
- word_valid and frame_err are never held longer than one clk.
- Framing errors:
  - WS change while counter < NUM_BITS: pulse frame_err, discard the partial word (output registers keep their old values), continue in the new channel's state.
  - Counter reaches SLOT_BITS with no WS change: pulse frame_err, go to SYNC.
- A left word with no right word following it never produces word_valid.

Optional Feature:
- Macro I2S_RX_ERR_CNT_EN.
- When defined:
  - Adds output err_count [7:0], incremented on every frame_err pulse.
  - Saturates at 255; cleared only by rst.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - state encoding (SYNC=2'd0, LEFT=2'd1, RIGHT=2'd2);
  - WS_LEFT=1'b0 constant;
  - default NUM_BITS/SLOT_BITS values, shared with the transmit side.
- Sub-module i2s_rx_slot holds the bit counter, shift register, and capture-done/early-end flags.
- The top holds the FSM and output registers.

Test Plan:
- Loopback from the transmit path: left=24'h123456, right=24'hABCDEF, NUM_BITS=24, SLOT_BITS=32 -> word_valid each frame with exactly those values; frame_err never asserts.
- From reset, stream starts mid-right-slot -> no outputs until the first WS 1->0; the first word_valid follows the first full left+right pair.
- WS toggled after only 10 bits of a left slot -> one frame_err pulse; left_word keeps its previous value; next full frame captured correctly.
- WS held at 0 for 40 strobes -> frame_err at strobe 32, FSM in SYNC, no word_valid until resync.
- rst asserted mid right slot while s_clk_pos=1 -> all outputs 0 the next clk, state SYNC; with I2S_RX_ERR_CNT_EN, err_count=0.
- With I2S_RX_ERR_CNT_EN, 300 forced framing errors -> err_count=255, no wrap.
